mux_port_arbiter: RTL

Round-robin arbiter that shares one 4:1, 5-bit register-address mux among four requesters (e.g. writeback, link-register, exception and debug paths). It grants one requester at a time, drives the mux `sel` code and a one-hot grant, and holds the grant for a multi-cycle transaction. It releases the grant on the holder's `last`, on a dropped request, or on a hold timeout. It sits between the requesting control units and the `sel` input of the address mux.

---
 rtl/mux_port_arbiter.sv | 112 +++++++++++
 1 files changed

// File: rtl/mux_port_arbiter.sv
// Round-robin arbiter for a shared 4:1 register-address mux.
// One holder at a time; the grant is released on last, on a dropped request, or on hold timeout.
module mux_port_arbiter #(
    parameter int HOLD_MAX = 8,
    parameter int CW       = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] req,
    input  logic [3:0] last,
    output logic [3:0] grant,
    output logic [1:0] sel,
    output logic       busy,
    output logic       timeout
);

    typedef enum logic {
        IDLE = 1'b0,
        OWN  = 1'b1
    } state_t;

    state_t          state_q, state_d;
    logic   [3:0]    grant_q, grant_d;
    logic   [1:0]    sel_q, sel_d;
    logic            busy_q, busy_d;
    logic            timeout_q, timeout_d;
    logic   [1:0]    ptr_q, ptr_d;
    logic   [CW-1:0] cnt_q, cnt_d;

    logic   [1:0]    win;
    logic   [1:0]    idx;
    logic            found;
    logic            hold_done;

    always_comb begin
        state_d   = state_q;
        grant_d   = grant_q;
        sel_d     = sel_q;
        busy_d    = busy_q;
        timeout_d = 1'b0;
        ptr_d     = ptr_q;
        cnt_d     = cnt_q;
        win       = ptr_q;
        idx       = ptr_q;
        found     = 1'b0;
        hold_done = (cnt_q == CW'(HOLD_MAX));

        // Scan ptr, ptr+1, ptr+2, ptr+3 (mod 4); the first requester wins.
        for (int k = 0; k < 4; k++) begin
            idx = ptr_q + 2'(k);
            if (!found && req[idx]) begin
                win   = idx;
                found = 1'b1;
            end
        end

        case (state_q)
            IDLE: begin
                if (found) begin
                    state_d = OWN;
                    grant_d = 4'b0001 << win;
                    sel_d   = win;
                    busy_d  = 1'b1;
                    cnt_d   = CW'(1);
                end
            end
            OWN: begin
                if (!req[sel_q] || last[sel_q] || hold_done) begin
                    state_d   = IDLE;
                    grant_d   = 4'b0000;
                    sel_d     = 2'b00;
                    busy_d    = 1'b0;
                    cnt_d     = '0;
                    ptr_d     = sel_q + 2'd1;
                    // A dropped request or a normal end takes precedence over the timeout.
                    timeout_d = req[sel_q] & ~last[sel_q];
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            grant_q   <= 4'b0000;
            sel_q     <= 2'b00;
            busy_q    <= 1'b0;
            timeout_q <= 1'b0;
            ptr_q     <= 2'b00;
            cnt_q     <= '0;
        end else begin
            state_q   <= state_d;
            grant_q   <= grant_d;
            sel_q     <= sel_d;
            busy_q    <= busy_d;
            timeout_q <= timeout_d;
            ptr_q     <= ptr_d;
            cnt_q     <= cnt_d;
        end
    end

    assign grant   = grant_q;
    assign sel     = sel_q;
    assign busy    = busy_q;
    assign timeout = timeout_q;

endmodule
